// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the EXE-stage iterative multiply/divide unit.
//   op_e       : operation select as presented on the unit's op port.
//   state_e    : sequencer states (IDLE -> CALC -> FIX -> IDLE).
//   MULDIV_ITER: CALC iterations per operation (one operand bit per cycle).
package muldiv_pkg;

  localparam int unsigned MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: two's-complement conditional negation applied when an
// operation retires. The magnitude datapath works on |a| and |b|; this block
// restores the signs of the product, quotient and remainder.
//   prod/neg_prod -> prod_fix : 64-bit product, negated when neg_prod
//   quo/neg_quo   -> quo_fix  : quotient, negated when neg_quo
//   rem/neg_rem   -> rem_fix  : remainder, negated when neg_rem
module muldiv_signfix #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] prod,
  input  logic              neg_prod,
  input  logic [XLEN-1:0]   quo,
  input  logic              neg_quo,
  input  logic [XLEN-1:0]   rem,
  input  logic              neg_rem,
  output logic [2*XLEN-1:0] prod_fix,
  output logic [XLEN-1:0]   quo_fix,
  output logic [XLEN-1:0]   rem_fix
);

  always_comb begin
    prod_fix = neg_prod ? ('0 - prod) : prod;
    quo_fix  = neg_quo  ? ('0 - quo)  : quo;
    rem_fix  = neg_rem  ? ('0 - rem)  : rem;
  end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One operand bit is processed per CALC cycle (32 cycles), then FIX applies
// sign correction and writes HI/LO while pulsing done.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   start, op, a, b   : launch request (sampled in IDLE only) and operands
//   wr_hi, wr_lo      : MTHI/MTLO enables (IDLE only), data on wdata
//   sel_hi, rdata     : combinational HI/LO read port (no forwarding)
//   busy, done        : operation in flight / one-cycle retire pulse
// Configuration: define MULDIV_DIV_EN to build the divider. Without it,
// DIV/DIVU retire immediately (done one cycle later, HI/LO untouched).
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic            sel_hi,
  output logic [XLEN-1:0] rdata,
  output logic            busy,
  output logic            done
);

  state_e state_q, state_d;

  // Multiply: acc holds {partial product, unconsumed multiplier bits}.
  // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;  // |multiplicand| or |divisor|
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              pneg_q, pneg_d;    // product / quotient negation
  logic              done_q, done_d;
  logic              skip_q, skip_d;    // divide request with no divider built

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] fix_prod;
  logic [XLEN-1:0]   fix_quo, fix_rem;

`ifdef MULDIV_DIV_EN
  logic              div_q, div_d;
  logic              rneg_q, rneg_d;    // remainder follows dividend sign
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN:0]     part_rem;          // 33-bit shifted partial remainder
  logic              rem_ge;
`endif

  assign a_neg = op_is_signed(op) & a[XLEN-1];
  assign b_neg = op_is_signed(op) & b[XLEN-1];
  assign a_mag = a_neg ? ('0 - a) : a;
  assign b_mag = b_neg ? ('0 - b) : b;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

`ifdef MULDIV_DIV_EN
  assign part_rem = {rem_q, acc_q[XLEN-1]};
  assign rem_ge   = part_rem >= {1'b0, mcand_q};
`endif

  muldiv_signfix #(
    .XLEN(XLEN)
  ) u_signfix (
    .prod     (acc_q),
    .neg_prod (pneg_q),
    .quo      (acc_q[XLEN-1:0]),
    .neg_quo  (pneg_q),
`ifdef MULDIV_DIV_EN
    .rem      (rem_q),
    .neg_rem  (rneg_q),
`else
    .rem      ('0),
    .neg_rem  (1'b0),
`endif
    .prod_fix (fix_prod),
    .quo_fix  (fix_quo),
    .rem_fix  (fix_rem)
  );

`ifndef MULDIV_DIV_EN
  logic unused_div;
  assign unused_div = ^{fix_quo, fix_rem};
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    pneg_d  = pneg_q;
    skip_d  = 1'b0;
    done_d  = skip_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    rem_d   = rem_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
`ifdef MULDIV_DIV_EN
          div_d  = op_is_div(op);
          rneg_d = a_neg;
          div0_d = (b == '0);
          rem_d  = '0;
          if (op_is_div(op)) begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            mcand_d = b_mag;
          end else begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mcand_d = a_mag;
          end
          pneg_d  = a_neg ^ b_neg;
          cnt_d   = '0;
          state_d = S_CALC;
`else
          if (op_is_div(op)) begin
            skip_d = 1'b1;
          end else begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mcand_d = a_mag;
            pneg_d  = a_neg ^ b_neg;
            cnt_d   = '0;
            state_d = S_CALC;
          end
`endif
        end
      end

      S_CALC: begin
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          rem_d = rem_ge ? XLEN'(part_rem - {1'b0, mcand_q}) : part_rem[XLEN-1:0];
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
`else
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
`endif
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MULDIV_ITER - 1)) state_d = S_FIX;
      end

      S_FIX: begin
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          hi_d = fix_rem;
          // Divide by zero: remainder already equals a; quotient forced to all ones.
          lo_d = div0_q ? '1 : fix_quo;
        end else begin
          hi_d = fix_prod[2*XLEN-1:XLEN];
          lo_d = fix_prod[XLEN-1:0];
        end
`else
        hi_d = fix_prod[2*XLEN-1:XLEN];
        lo_d = fix_prod[XLEN-1:0];
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      pneg_q  <= 1'b0;
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      pneg_q  <= pneg_d;
      done_q  <= done_d;
      skip_q  <= skip_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign rdata = sel_hi ? hi_q : lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed plus randomized checks of exe_muldiv against an
// arithmetic HI/LO model. Expectations for DIV/DIVU follow MULDIV_DIV_EN.
module tb_exe_muldiv;

  logic        clock = 1'b0;
  logic        reset, start, wr_hi, wr_lo, sel_hi, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, rdata;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_hi  = '0;
  logic [31:0] exp_lo  = '0;

  exe_muldiv #(
    .XLEN(32)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .wdata  (wdata),
    .sel_hi (sel_hi),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_regs(string tag);
    sel_hi = 1'b1;
    #1;
    check({tag, ".hi"}, rdata, exp_hi);
    sel_hi = 1'b0;
    #1;
    check({tag, ".lo"}, rdata, exp_lo);
  endtask

  // Architectural result of one operation, computed with wide integer arithmetic.
  function automatic void model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint          p, sx, sy;
    longint unsigned pu;
    case (o)
      2'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {exp_hi, exp_lo} = p;
      end
      2'd1: begin
        pu = {32'b0, x} * {32'b0, y};
        {exp_hi, exp_lo} = pu;
      end
      default: begin
        if (DivEn) begin
          if (y == 32'd0) begin
            exp_hi = x;
            exp_lo = 32'hFFFF_FFFF;
          end else if (o == 2'd2) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            exp_lo = 32'(sx / sy);
            exp_hi = 32'(sx % sy);
          end else begin
            exp_lo = x / y;
            exp_hi = x % y;
          end
        end
      end
    endcase
  endfunction

  // Issue one operation and follow it to its done cycle; returns in that cycle.
  task automatic run_op(string tag, logic [1:0] o, logic [31:0] x, logic [31:0] y);
    int lat, bcnt;
    bit launched;
    launched = (o < 2'd2) || DivEn;
    op = o; a = x; b = y; start = 1'b1;
    tick;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    model(o, x, y);
    check({tag, ".done_at_start"}, 32'(done), 32'd0);
    if (launched) begin
      check({tag, ".busy_at_start"}, 32'(busy), 32'd1);
      lat = 0;
      bcnt = 1;
      while (!done && lat < 40) begin
        tick;
        lat++;
        if (!done && busy) bcnt++;
      end
      check({tag, ".latency"}, 32'(lat), 32'd33);
      check({tag, ".busy_cycles"}, 32'(bcnt), 32'd33);
      check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    end else begin
      check({tag, ".busy_skip"}, 32'(busy), 32'd0);
      tick;
      check({tag, ".done_skip"}, 32'(done), 32'd1);
      check({tag, ".busy_skip2"}, 32'(busy), 32'd0);
    end
    check_regs(tag);
  endtask

  initial begin
    int lat, seen;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0; sel_hi = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_regs("rst");

    // Test-plan vectors.
    run_op("mult_neg2x3", 2'd0, 32'hFFFF_FFFE, 32'd3);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", 2'd3, 32'd100, 32'd0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0_neg", 2'd2, 32'h8000_0003, 32'd0);

    // MTLO / MTHI in IDLE.
    tick;
    wdata = 32'hCAFE_0001; wr_lo = 1'b1;
    tick;
    wr_lo = 1'b0; exp_lo = 32'hCAFE_0001;
    check_regs("mtlo");
    wdata = 32'h0BAD_F00D; wr_hi = 1'b1;
    tick;
    wr_hi = 1'b0; exp_hi = 32'h0BAD_F00D;
    check_regs("mthi");

    // MTHI and a second start while busy are both ignored.
    op = 2'd0; a = 32'd5; b = 32'hFFFF_FFF9; start = 1'b1;
    tick;
    start = 1'b0;
    model(2'd0, 32'd5, 32'hFFFF_FFF9);
    tick; tick; tick;
    wr_hi = 1'b1; wdata = 32'h1234; start = 1'b1; op = 2'd1;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick;
    wr_hi = 1'b0; start = 1'b0;
    check("busy_ign.busy", 32'(busy), 32'd1);
    sel_hi = 1'b1;
    #1;
    check("busy_ign.hi_during", rdata, exp_hi == 32'h1234 ? 32'h0BAD_F00D : 32'h0BAD_F00D);
    lat = 0;
    while (!done && lat < 60) begin
      tick;
      lat++;
    end
    check("busy_ign.remaining", 32'(lat), 32'd29);
    check_regs("busy_ign");
    tick;
    check("busy_ign.no_second", 32'(busy), 32'd0);
    check("busy_ign.done_low", 32'(done), 32'd0);

    // Write and start in the same IDLE cycle: write lands now, result later.
    wr_hi = 1'b1; wdata = 32'h0000_DEAD; op = 2'd1; a = 32'd1000; b = 32'd1000; start = 1'b1;
    tick;
    wr_hi = 1'b0; start = 1'b0;
    sel_hi = 1'b1;
    #1;
    check("wr_start.hi_now", rdata, 32'h0000_DEAD);
    model(2'd1, 32'd1000, 32'd1000);
    lat = 0;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
    check_regs("wr_start");

    // Reset in CALC cycle 10 aborts without a done pulse.
    tick;
    op = 2'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_regs("midrst");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done || busy) seen++;
    end
    check("midrst.quiet", 32'(seen), 32'd0);

    // Randomized operations, issued back to back in each done cycle.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1, 2:    ry = 32'($urandom_range(1, 15));
        3:       ry = 32'hFFFF_FFFF;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) rx = 32'h8000_0000;
      run_op("rand", ro, rx, ry);
    end

    tick;
    check("final.done_low", 32'(done), 32'd0);
    check("final.busy_low", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage, beside the ALU. Performs 32-bit signed/unsigned multiply and divide over 32 iteration cycles, holds the results in architectural HI/LO registers and presents HI or LO as a read operand. The selected value feeds the EXE result mux, whose output becomes the address/data `result` consumed by the memory stage. The control unit stalls the front end while `busy` is high.

## Interface

- `XLEN`, 32: operand and HI/LO width. Only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a`  in  32  rs operand: multiplicand or dividend.
- `b`  in  32  rt operand: multiplier or divisor.
- `wr_hi`  in  1  MTHI write enable.
- `wr_lo`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `sel_hi`  in  1  1 selects HI onto `rdata`, 0 selects LO.
- `rdata`  out  32  combinational `sel_hi ? hi : lo`.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.

## Operation

- States: IDLE, CALC, FIX. All are registered.
- IDLE with `start`=1: latch `op`; latch |a| and |b| (magnitudes for signed ops); latch the result signs; clear the 6-bit counter; go to CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: restoring divide, one quotient bit per cycle. The partial remainder is 33 bits wide.
- CALC exits to FIX when the counter reaches 31 (32 iterations).
- FIX:
  - Apply sign correction. Product is negated if the signs of a and b differ.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
  - Write HI/LO: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Go to IDLE and pulse `done`.
- Divide by zero (b=0, DIV or DIVU): HI=a unmodified, LO=32'hFFFFFFFF. Latency is normal.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- `start` while `busy`: ignored.
- `wr_hi`/`wr_lo` while `busy`: ignored.
- `wr_hi`/`wr_lo` while IDLE: HI/LO written at the edge.
- `start` and `wr_*` in the same IDLE cycle: the write takes effect and the operation launches. The operation's result later overwrites HI/LO.
- `rdata` always reflects the current HI/LO registers. No forwarding of in-flight results.

## Timing

- Reset: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. `rdata`=0.
- Reset mid-operation aborts the operation. HI/LO are cleared and no `done` is produced.
- `start` sampled at edge N:
  - `busy`=1 after edges N..N+32: 32 CALC cycles plus 1 FIX cycle.
  - At edge N+33, HI/LO are updated, `done`=1 for that one cycle, and `busy`=0.
- `start` during the `done` cycle is accepted. Back-to-back throughput is one operation per 34 cycles.
- Total latency from `start` to valid `rdata`: 34 edges.

## Configuration

- `MULDIV_DIV_EN` defined: DIV and DIVU are implemented as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath is not built.
  - DIV/DIVU `start` goes directly to IDLE. `done` pulses at edge N+1, `busy` is never raised, and HI/LO are unchanged.
  - MULT/MULTU are unaffected.

## Structure

- Package `muldiv_pkg` contains:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - state encodings `S_IDLE`, `S_CALC`, `S_FIX`.
  - `MULDIV_ITER`=32.
- One combinational sub-module, `muldiv_signfix`. It performs two's-complement conditional negation of the 64-bit product and of the quotient/remainder pair. It is used in FIX.

## Test plan

- MULT a=0xFFFFFFFE (−2), b=3 → at N+33: HI=0xFFFFFFFF, LO=0xFFFFFFFA; `done` high exactly one cycle; `busy` high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU a=100, b=0 → HI=100, LO=0xFFFFFFFF. In a second run, DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- Busy interactions:
  - MTHI wdata=0x1234 and a second `start` issued while `busy` → both ignored; the final HI/LO equal the first operation's result.
  - MTLO issued in IDLE → LO=wdata next cycle; `rdata` with `sel_hi`=0 shows it.
- `reset` asserted at CALC cycle 10 → next cycle: IDLE, `busy`=0, HI=LO=0, and no `done` pulse follows.
- Without `MULDIV_DIV_EN`: DIV issued → `done` pulses at N+1 and HI/LO are unchanged.
